average: RTL and testbench

AVERAGE -- requirements
Module: average

---
 rtl/average_pkg.sv | 22 ++
 rtl/avg_window.sv | 32 +++
 rtl/average.sv | 47 ++++
 tb/tb_average.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/average_pkg.sv
// Shared sizing and output scaling for the 8-sample moving average.
// Define AVERAGE_ROUND_EN to round half up instead of truncating.
package average_pkg;

    localparam int DATA_W   = 8;
    localparam int WIN      = 8;
    localparam int LOG2_WIN = 3;
    localparam int SUM_W    = 11;
    localparam int CNT_W    = 4;

    // Divide a window sum by WIN; rounding headroom is safe since 2040 + 4 < 2048.
    function automatic logic [DATA_W-1:0] scale(input logic [SUM_W-1:0] s);
        logic [SUM_W-1:0] r;
`ifdef AVERAGE_ROUND_EN
        r = s + SUM_W'(1 << (LOG2_WIN - 1));
`else
        r = s;
`endif
        return r[SUM_W-1:LOG2_WIN];
    endfunction

endpackage

// File: rtl/avg_window.sv
// Sample shift register for the moving average; exposes the entry that the
// next capture drops so the running sum can subtract it.
module avg_window
    import average_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] oldest
);

    genvar gi;
    generate
        for (gi = 0; gi < WIN; gi++) begin : g_stage
            logic [DATA_W-1:0] stage_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (!reset) stage_reg <= '0;
                    else        stage_reg <= data;
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (!reset) stage_reg <= '0;
                    else        stage_reg <= g_stage[gi-1].stage_reg;
                end
            end
        end
    endgenerate

    assign oldest = g_stage[WIN-1].stage_reg;

endmodule

// File: rtl/average.sv
// Moving average of the last 8 unsigned samples with a fill-tracking valid.
// Build option AVERAGE_ROUND_EN selects round-half-up output scaling.
module average
    import average_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    output logic              valid,
    output logic [DATA_W-1:0] out
);

    logic [DATA_W-1:0] oldest;
    logic [SUM_W-1:0]  sum_reg;
    logic [SUM_W-1:0]  sum_next;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;

    avg_window u_window (
        .clk    (clk),
        .reset  (reset),
        .data   (data),
        .oldest (oldest)
    );

    // The sum always contains the dropped sample, so the subtraction never underflows.
    always_comb begin
        sum_next   = sum_reg + SUM_W'(data) - SUM_W'(oldest);
        count_next = count_reg;
        if (count_reg != CNT_W'(WIN)) count_next = count_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sum_reg   <= '0;
            count_reg <= '0;
            out       <= '0;
            valid     <= 1'b0;
        end else begin
            sum_reg   <= sum_next;
            count_reg <= count_next;
            out       <= scale(sum_next);
            valid     <= (count_next == CNT_W'(WIN));
        end
    end

endmodule

// File: tb/tb_average.sv
// Scoreboarded bench for the moving average: stimulus pushes expected outputs,
// a negedge monitor pops and compares whenever valid is presented.
module tb_average;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data = 8'h00;
    logic       valid;
    logic [7:0] out;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid_seen = 0;
    bit mon_en = 1'b0;

    logic [7:0] exp_q[$];
    int         hist[$];

    average dut (
        .clk   (clk),
        .reset (reset),
        .data  (data),
        .valid (valid),
        .out   (out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_avg();
        int s;
        s = 0;
        foreach (hist[i]) s += hist[i];
`ifdef AVERAGE_ROUND_EN
        s += 4;
`endif
        return 8'(s / 8);
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // One clock: drive inputs, let the edge happen, then update the reference.
    task automatic step(input logic [7:0] d, input logic rst_n);
        @(negedge clk);
        data  = d;
        reset = rst_n;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            hist.delete();
        end else begin
            hist.push_back(int'(d));
            if (hist.size() > 8) void'(hist.pop_front());
            if (hist.size() == 8) exp_q.push_back(ref_avg());
        end
    endtask

    // Monitor: valid must coincide with a pending expectation, and out must match it.
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if (valid !== (exp_q.size() != 0)) begin
                n_fail++;
                $display("FAIL mon_valid: got %0b, required %0b", valid, exp_q.size() != 0);
                exp_q.delete();
            end else if (valid) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                n_valid_seen++;
                n_checks++;
                if (out !== e) begin
                    n_fail++;
                    $display("FAIL mon_out: got 0x%0h, required 0x%0h", out, e);
                end
            end
        end
    end

    initial begin
        int seen0;
        // Reset state
        step(8'hAA, 1'b0);
        step(8'h55, 1'b0);
        check("reset_valid", valid, 0);
        check("reset_out", out, 8'h00);
        mon_en = 1'b1;

        // Constant 0x10: valid low for 7 edges, out=0x10 on the 8th
        for (int i = 0; i < 7; i++) begin
            step(8'h10, 1'b1);
            check($sformatf("fill10_valid%0d", i), valid, 0);
        end
        step(8'h10, 1'b1);
        check("win10_valid", valid, 1);
        check("win10_out", out, 8'h10);

        // Ramp 0..7: sum 28
        step(8'h00, 1'b0);
        for (int i = 0; i < 8; i++) step(8'(i), 1'b1);
`ifdef AVERAGE_ROUND_EN
        check("ramp_out", out, 8'h04);
`else
        check("ramp_out", out, 8'h03);
`endif

        // Saturated input then decay
        step(8'h00, 1'b0);
        for (int i = 0; i < 8; i++) step(8'hFF, 1'b1);
        check("ff_out", out, 8'hFF);
        step(8'h00, 1'b1);
        check("decay1_out", out, 8'hDF);
        step(8'h00, 1'b1);
        check("decay2_out", out, 8'hBF);
        for (int i = 0; i < 6; i++) step(8'h00, 1'b1);
        check("decay_end_out", out, 8'h00);
        check("decay_end_valid", valid, 1);

        // Zeros then a single 0x80
        for (int i = 0; i < 8; i++) step(8'h00, 1'b1);
        step(8'h80, 1'b1);
        check("impulse_out", out, 8'h10);

        // Mid-stream reset after 5 samples
        step(8'h00, 1'b0);
        for (int i = 0; i < 5; i++) step(8'h40, 1'b1);
        step(8'h40, 1'b0);
        check("midrst_valid", valid, 0);
        check("midrst_out", out, 8'h00);
        for (int i = 0; i < 7; i++) step(8'h20, 1'b1);
        check("refill_valid7", valid, 0);
        step(8'h20, 1'b1);
        check("refill_valid8", valid, 1);
        check("refill_out", out, 8'h20);

        // Random stream: 128 samples give 121 valid outputs
        step(8'h00, 1'b0);
        @(negedge clk);
        seen0 = n_valid_seen;
        for (int i = 0; i < 128; i++) step(8'($urandom_range(0, 255)), 1'b1);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        check("rand_valid_count", n_valid_seen - seen0, 121);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
